// File: rtl/cfg_param_pkg.sv
// Shared types and default values for the configuration-parameter responder.
// Field order, op encoding and defaults are fixed here and used by every block.
package cfg_param_pkg;

    localparam int CFG_DW      = 16;
    localparam int CFG_NFIELD  = 4;

    typedef enum logic [1:0] {
        OP_WRITE         = 2'd0,
        OP_READ          = 2'd1,
        OP_RESTORE_FIELD = 2'd2,
        OP_RESTORE_ALL   = 2'd3
    } cfg_op_e;

    typedef enum logic [1:0] {
        F_WIDTH = 2'd0,
        F_W     = 2'd1,
        F_ID    = 2'd2,
        F_S     = 2'd3
    } cfg_field_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Indexed by cfg_field_e: WIDTH, W, ID, S
    localparam logic [CFG_DW-1:0] DEF_VAL [CFG_NFIELD] = '{16'd32, 16'd8, 16'd0, 16'd24};

    function automatic logic [CFG_DW-1:0] default_of(input logic [1:0] field);
        return DEF_VAL[field];
    endfunction

endpackage

// File: rtl/cfg_field_bank.sv
// Parameter registers of one instance: a write port and a restore-to-default port.
// Restore wins when both target the same field in the same cycle.
module cfg_field_bank
    import cfg_param_pkg::*;
#(
    parameter int NUM_FIELD = 4,
    parameter int DW        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [1:0]              wr_field,
    input  logic [DW-1:0]           wr_data,
    input  logic                    rs_en,
    input  logic [1:0]              rs_field,
    output logic [NUM_FIELD*DW-1:0] values
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FIELD; f++) begin
                values[f*DW +: DW] <= DW'(default_of(2'(f)));
            end
        end else begin
            for (int f = 0; f < NUM_FIELD; f++) begin
                if (rs_en && rs_field == 2'(f)) begin
                    values[f*DW +: DW] <= DW'(default_of(2'(f)));
                end else if (wr_en && wr_field == 2'(f)) begin
                    values[f*DW +: DW] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/cfg_param_responder.sv
// Runtime parameter-table responder: single-outstanding request/response bus
// serving write, read, restore-field and restore-all over NUM_INST field banks.
module cfg_param_responder
    import cfg_param_pkg::*;
#(
    parameter int NUM_INST  = 4,
    parameter int NUM_FIELD = 4,
    parameter int DW        = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [1:0]                       req_op,
    input  logic [3:0]                       req_inst,
    input  logic [1:0]                       req_field,
    input  logic [DW-1:0]                    req_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DW-1:0]                    rsp_rdata,
    output logic                             rsp_err,
    output logic [NUM_INST*NUM_FIELD*DW-1:0] cfg_table,
    output logic [1:0]                       dbg_state
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_WALK = S_WALK;
    localparam logic [1:0] ST_RESP = S_RESP;

    // Handshake: a request transfers on an edge where req_valid & req_ready;
    // a response transfers on an edge where rsp_valid & rsp_ready. Each side
    // holds its payload stable while its valid is high and not yet taken.

    logic [1:0]          state;
    logic [1:0]          walk_cnt;
    logic [3:0]          lat_inst;
    logic [DW-1:0]       rsp_rdata_q;
    logic                rsp_err_q;
    logic                accept;
    logic                inst_err;
    logic [DW-1:0]       rd_val;
    logic [NUM_INST-1:0] wr_en;
    logic [NUM_INST-1:0] rs_en;
    logic [1:0]          rs_field;

    assign req_ready = rst_n && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign inst_err  = (32'(req_inst) >= NUM_INST);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state;
    assign rs_field  = (state == ST_WALK) ? walk_cnt : req_field;

    // Immediate ops land on the accept edge; the walk restores one field per cycle.
    always_comb begin
        wr_en  = '0;
        rs_en  = '0;
        rd_val = '0;
        for (int i = 0; i < NUM_INST; i++) begin
            wr_en[i] = accept && !inst_err && req_op == OP_WRITE && req_inst == 4'(i);
            rs_en[i] = (accept && !inst_err && req_op == OP_RESTORE_FIELD && req_inst == 4'(i))
                    || (state == ST_WALK && lat_inst == 4'(i));
            for (int f = 0; f < NUM_FIELD; f++) begin
                if (req_inst == 4'(i) && req_field == 2'(f)) begin
                    rd_val = cfg_table[(i*NUM_FIELD+f)*DW +: DW];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_INST; gi++) begin : g_bank
        cfg_field_bank #(
            .NUM_FIELD (NUM_FIELD),
            .DW        (DW)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[gi]),
            .wr_field (req_field),
            .wr_data  (req_wdata),
            .rs_en    (rs_en[gi]),
            .rs_field (rs_field),
            .values   (cfg_table[gi*NUM_FIELD*DW +: NUM_FIELD*DW])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            walk_cnt    <= 2'd0;
            lat_inst    <= 4'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_inst  <= req_inst;
                        walk_cnt  <= 2'd0;
                        rsp_err_q <= inst_err;
                        state     <= ST_RESP;
                        if (inst_err) begin
                            rsp_rdata_q <= '0;
                        end else begin
                            case (req_op)
                                OP_WRITE:         rsp_rdata_q <= req_wdata;
                                OP_READ:          rsp_rdata_q <= rd_val;
                                OP_RESTORE_FIELD: rsp_rdata_q <= DW'(default_of(req_field));
                                default: begin
                                    rsp_rdata_q <= '0;
                                    state       <= ST_WALK;
                                end
                            endcase
                        end
                    end
                end
                ST_WALK: begin
                    walk_cnt <= walk_cnt + 2'd1;
                    if (walk_cnt == 2'(NUM_FIELD-1)) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_param_responder.sv
// Self-checking bench for cfg_param_responder: vector table through a
// scoreboard, plus backpressure, walk-progression and mid-walk reset sequences.
module tb_cfg_param_responder;

    localparam int NI = 4;
    localparam int NF = 4;
    localparam int DW = 16;
    localparam int TW = NI*NF*DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [3:0]    req_inst;
    logic [1:0]    req_field;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [TW-1:0] cfg_table;
    logic [1:0]    dbg_state;

    cfg_param_responder #(.NUM_INST(NI), .NUM_FIELD(NF), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_inst  (req_inst),
        .req_field (req_field),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .cfg_table (cfg_table),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [3:0]    inst;
        logic [1:0]    field;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] model [NI][NF];
    logic [DW-1:0] defv  [NF];
    vec_t          vecs  [15];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [3:0] inst, input logic [1:0] field,
                                input logic [DW-1:0] wd, input logic [DW-1:0] er, input logic ee, input int lat);
        vec_t v;
        v.op = op; v.inst = inst; v.field = field; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++)
            for (int f = 0; f < NF; f++) model[i][f] = defv[f];
    endtask

    task automatic model_apply(input vec_t v);
        if (32'(v.inst) < NI) begin
            case (v.op)
                2'd0: model[v.inst][v.field] = v.wdata;
                2'd2: model[v.inst][v.field] = defv[v.field];
                2'd3: for (int f = 0; f < NF; f++) model[v.inst][f] = defv[f];
                default: ;
            endcase
        end
    endtask

    task automatic check_table(input string name);
        logic [TW-1:0] e;
        e = '0;
        for (int i = 0; i < NI; i++)
            for (int f = 0; f < NF; f++) e[(i*NF+f)*DW +: DW] = model[i][f];
        check(name, cfg_table, e);
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1'b1; req_op = v.op; req_inst = v.inst;
        req_field = v.field; req_wdata = v.wdata;
    endtask

    task automatic wait_ready(input string name);
        int g = 0;
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        if (!req_ready) begin n_tests++; n_fail++; $display("FAIL %s: req_ready timeout", name); end
    endtask

    task automatic compare_rsp(input string name);
        logic [DW:0] e;
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++; $display("FAIL %s: response with empty scoreboard", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_rsp"}, TW'({rsp_err, rsp_rdata}), TW'(e));
        end
    endtask

    // Called at a negedge with the responder idle; returns at a negedge, idle again.
    task automatic run_req(input string name, input vec_t v);
        int lat;
        wait_ready(name);
        drive(v);
        @(posedge clk);
        exp_q.push_back({v.exp_err, v.exp_rdata});
        model_apply(v);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        check({name, "_lat"}, TW'(lat), TW'(v.exp_lat));
        compare_rsp(name);
        check_table({name, "_table"});
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        logic [DW-1:0] ev;
        int seen;
        defv[0] = 16'd32; defv[1] = 16'd8; defv[2] = 16'd0; defv[3] = 16'd24;
        model_reset();

        vecs[0]  = mk(2'd0, 4'd2, 2'd1, 16'h0018, 16'h0018, 1'b0, 1);
        vecs[1]  = mk(2'd1, 4'd2, 2'd1, 16'h0000, 16'h0018, 1'b0, 1);
        vecs[2]  = mk(2'd0, 4'd1, 2'd0, 16'd48,   16'd48,   1'b0, 1);
        vecs[3]  = mk(2'd0, 4'd1, 2'd2, 16'd5,    16'd5,    1'b0, 1);
        vecs[4]  = mk(2'd2, 4'd1, 2'd1, 16'hFFFF, 16'd8,    1'b0, 1);
        vecs[5]  = mk(2'd1, 4'd1, 2'd0, 16'h0000, 16'd48,   1'b0, 1);
        vecs[6]  = mk(2'd1, 4'd1, 2'd2, 16'h0000, 16'd5,    1'b0, 1);
        vecs[7]  = mk(2'd3, 4'd1, 2'd0, 16'h1234, 16'd0,    1'b0, 5);
        vecs[8]  = mk(2'd1, 4'd1, 2'd0, 16'h0000, 16'd32,   1'b0, 1);
        vecs[9]  = mk(2'd0, 4'd7, 2'd0, 16'hBEEF, 16'd0,    1'b1, 1);
        vecs[10] = mk(2'd1, 4'd7, 2'd3, 16'h0000, 16'd0,    1'b1, 1);
        vecs[11] = mk(2'd1, 4'd2, 2'd1, 16'h0000, 16'h0018, 1'b0, 1);
        vecs[12] = mk(2'd0, 4'd3, 2'd3, 16'hA5A5, 16'hA5A5, 1'b0, 1);
        vecs[13] = mk(2'd2, 4'd3, 2'd3, 16'h0000, 16'd24,   1'b0, 1);
        vecs[14] = mk(2'd1, 4'd0, 2'd3, 16'h0000, 16'd24,   1'b0, 1);

        // Clock/reset
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_inst = 4'd0;
        req_field = 2'd0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", TW'(req_ready), TW'(0));
        check("rst_rsp_valid", TW'(rsp_valid), TW'(0));
        check("rst_rsp_rdata", TW'(rsp_rdata), TW'(0));
        check("rst_rsp_err", TW'(rsp_err), TW'(0));
        check_table("rst_table");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", TW'(req_ready), TW'(1));
        check("idle_state", TW'(dbg_state), TW'(0));

        for (int k = 0; k < 15; k++) run_req($sformatf("vec%0d", k), vecs[k]);

        // Backpressure: response held 3 cycles while a second request waits
        rsp_ready = 1'b0;
        wait_ready("bp");
        drive(mk(2'd1, 4'd2, 2'd1, 16'h0000, 16'h0018, 1'b0, 1));
        @(posedge clk);
        exp_q.push_back({1'b0, 16'h0018});
        @(negedge clk);
        v = mk(2'd0, 4'd0, 2'd0, 16'h1234, 16'h1234, 1'b0, 1);
        drive(v);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_valid%0d", c), TW'(rsp_valid), TW'(1));
            check($sformatf("bp_rdata%0d", c), TW'(rsp_rdata), TW'(16'h0018));
            check($sformatf("bp_ready%0d", c), TW'(req_ready), TW'(0));
            if (c < 2) @(negedge clk);
        end
        compare_rsp("bp_first");
        check_table("bp_pending_table");
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after", TW'(req_ready), TW'(1));
        @(posedge clk);
        exp_q.push_back({1'b0, 16'h1234});
        model_apply(v);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_second_valid", TW'(rsp_valid), TW'(1));
        compare_rsp("bp_second");
        check_table("bp_second_table");
        @(negedge clk);

        // Walk progression: distinct values in inst 0, then restore-all
        for (int f = 0; f < NF; f++)
            run_req($sformatf("pre%0d", f), mk(2'd0, 4'd0, 2'(f), 16'(f+1), 16'(f+1), 1'b0, 1));
        wait_ready("walk");
        v = mk(2'd3, 4'd0, 2'd0, 16'h0000, 16'd0, 1'b0, 5);
        drive(v);
        @(posedge clk);
        exp_q.push_back({1'b0, 16'd0});
        model_apply(v);
        for (int k = 0; k < NF; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check($sformatf("walk_busy%0d", k), TW'(rsp_valid), TW'(0));
            for (int j = 0; j < NF; j++) begin
                ev = (j < k) ? defv[j] : 16'(j+1);
                check($sformatf("walk_k%0d_f%0d", k, j), TW'(cfg_table[j*DW +: DW]), TW'(ev));
            end
        end
        @(negedge clk);
        check("walk_rsp_valid", TW'(rsp_valid), TW'(1));
        compare_rsp("walk");
        check_table("walk_table");
        @(negedge clk);

        // Reset in the middle of a walk drops the response
        run_req("mw_pre", mk(2'd0, 4'd3, 2'd0, 16'h7777, 16'h7777, 1'b0, 1));
        wait_ready("mw");
        drive(mk(2'd3, 4'd3, 2'd0, 16'h0000, 16'd0, 1'b0, 5));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("mw_rsp_valid", TW'(rsp_valid), TW'(0));
        check_table("mw_table");
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mw_no_response", TW'(seen), TW'(0));
        check("mw_req_ready", TW'(req_ready), TW'(1));
        run_req("mw_after", mk(2'd1, 4'd1, 2'd0, 16'h0000, 16'd32, 1'b0, 1));

        check("sb_empty", TW'(exp_q.size()), TW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
